payload_rd_engine: RTL

- Read-side counterpart of the payload write bus: the write side stores payload words and hands back a start address; this block takes that start address and streams the packet back out of payload memory.
- Walks consecutive payload-memory words from the start address, wrapping modulo depth, until it reads a word flagged last.
- Emits words on a valid/ready stream and returns the freed region (start address, word count) to the allocator.
- Discards packets whose first-word TTL is zero; the discard is visible only as a release and a drop pulse.

---
 rtl/payload_rd_engine.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/payload_rd_engine.sv
// Payload read engine: streams a stored packet from payload memory, returns the freed region.
// Optional statistics outputs are enabled by defining PAYLOAD_RD_STATS_EN.
module payload_rd_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int TTL_W  = 8,
    parameter int BC_W   = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_address,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_is_last,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [TTL_W-1:0]  mem_rd_ttl,
    input  logic [BC_W-1:0]   mem_rd_byte_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_is_last,
    output logic [DATA_W-1:0] out_data,
    output logic [TTL_W-1:0]  out_ttl,
    output logic [BC_W-1:0]   out_byte_count,
    output logic              rel_valid,
    output logic [ADDR_W-1:0] rel_address,
    output logic [ADDR_W:0]   rel_word_count,
    output logic              drop_pulse
`ifdef PAYLOAD_RD_STATS_EN
    ,
    output logic [31:0]       stat_pkt_count,
    output logic [31:0]       stat_drop_count
`endif
);

    localparam int ENTRY_W = DATA_W + TTL_W + BC_W + 1;
    localparam logic [ADDR_W:0] WCNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   start_r;
    logic [ADDR_W-1:0]   cur_r;
    logic [ADDR_W:0]     wcnt_r;
    logic [TTL_W-1:0]    ttl_r;
    logic                drop_r;
    logic                ret_r;
    logic                drop_rel_r;
    logic                req_ready_r;
    logic [1:0]          occ_r;
    logic [ENTRY_W-1:0]  e0_r;
    logic [ENTRY_W-1:0]  e1_r;

    logic                pop_s;
    logic                ret_live_s;
    logic                first_s;
    logic                word_drop_s;
    logic                push_s;
    logic [TTL_W-1:0]    push_ttl_s;
    logic [ENTRY_W-1:0]  new_entry_s;
    logic [2:0]          credit_s;
    logic                issue_s;
    logic                norm_rel_s;
    logic                last_ret_s;

    // Only returns seen while reading belong to the packet; anything arriving in FLUSH is the speculative read.
    assign pop_s       = (occ_r != 2'd0) & out_ready;
    assign ret_live_s  = ret_r & (state_r == READ);
    assign first_s     = (wcnt_r == {(ADDR_W+1){1'b0}});
    assign word_drop_s = first_s ? (mem_rd_ttl == {TTL_W{1'b0}}) : drop_r;
    assign push_s      = ret_live_s & ~word_drop_s;
    assign push_ttl_s  = first_s ? mem_rd_ttl : ttl_r;
    assign new_entry_s = {mem_rd_is_last, mem_rd_byte_count, push_ttl_s, mem_rd_data};
    assign last_ret_s  = ret_live_s & mem_rd_is_last;

    // A new read may issue only if its word is guaranteed a FIFO slot when it lands.
    assign credit_s    = {1'b0, occ_r} + {2'b00, ret_r} - {2'b00, pop_s};
    assign issue_s     = (state_r == READ) & (credit_s < 3'd2);
    assign norm_rel_s  = (state_r == FLUSH) & ~drop_r & pop_s & e0_r[ENTRY_W-1];

    assign req_ready      = req_ready_r;
    assign mem_rd_en      = issue_s;
    assign mem_rd_addr    = cur_r;
    assign out_valid      = (occ_r != 2'd0);
    assign out_data       = e0_r[DATA_W-1:0];
    assign out_ttl        = e0_r[DATA_W +: TTL_W];
    assign out_byte_count = e0_r[DATA_W+TTL_W +: BC_W];
    assign out_is_last    = e0_r[ENTRY_W-1];
    assign rel_valid      = drop_rel_r | norm_rel_s;
    assign rel_address    = start_r;
    assign rel_word_count = wcnt_r;
    assign drop_pulse     = drop_rel_r;

    // Packet FSM: request capture, address walk, word counting and release sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            start_r     <= {ADDR_W{1'b0}};
            cur_r       <= {ADDR_W{1'b0}};
            wcnt_r      <= {(ADDR_W+1){1'b0}};
            ttl_r       <= {TTL_W{1'b0}};
            drop_r      <= 1'b0;
            ret_r       <= 1'b0;
            drop_rel_r  <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            ret_r      <= issue_s;
            drop_rel_r <= last_ret_s & word_drop_s;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        start_r     <= req_address;
                        cur_r       <= req_address;
                        wcnt_r      <= {(ADDR_W+1){1'b0}};
                        drop_r      <= 1'b0;
                        req_ready_r <= 1'b0;
                        state_r     <= READ;
                    end
                end
                READ: begin
                    if (issue_s) begin
                        cur_r <= cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                    if (ret_live_s) begin
                        if (wcnt_r != WCNT_MAX) begin
                            wcnt_r <= wcnt_r + {{ADDR_W{1'b0}}, 1'b1};
                        end
                        if (first_s) begin
                            ttl_r  <= mem_rd_ttl;
                            drop_r <= (mem_rd_ttl == {TTL_W{1'b0}});
                        end
                        if (mem_rd_is_last) begin
                            state_r <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (drop_rel_r | norm_rel_s) begin
                        req_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    req_ready_r <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Two-entry skid FIFO; entry 0 is the head that drives the output stream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_r <= 2'd0;
            e0_r  <= {ENTRY_W{1'b0}};
            e1_r  <= {ENTRY_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        e0_r <= new_entry_s;
                    end else begin
                        e1_r <= new_entry_s;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    e0_r  <= e1_r;
                    occ_r <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        e0_r <= e1_r;
                        e1_r <= new_entry_s;
                    end else begin
                        e0_r <= new_entry_s;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

`ifdef PAYLOAD_RD_STATS_EN
    logic [31:0] stat_pkt_r;
    logic [31:0] stat_drop_r;

    // Saturating release counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pkt_r  <= 32'd0;
            stat_drop_r <= 32'd0;
        end else begin
            if (norm_rel_s && (stat_pkt_r != 32'hFFFF_FFFF)) begin
                stat_pkt_r <= stat_pkt_r + 32'd1;
            end
            if (drop_rel_r && (stat_drop_r != 32'hFFFF_FFFF)) begin
                stat_drop_r <= stat_drop_r + 32'd1;
            end
        end
    end

    assign stat_pkt_count  = stat_pkt_r;
    assign stat_drop_count = stat_drop_r;
`endif

endmodule
